seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clock cycles each digit stays selected; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, SHALL be synchronous and active-low.
REQ-004 load  input  1  request to convert value_i; sampled only when ready=1.
REQ-005 value_i  input  14  unsigned binary value to display.
REQ-006 ready  output  1  high when idle and able to accept load.
REQ-007 ovf  output  1  high when the last accepted value_i exceeded 9999.
REQ-008 digit_num  output  4  BCD code of the currently selected digit, driving the seven-segment decoder; codes above 9 mean blank.
REQ-009 digit_sel  output  4  active-low one-hot digit enable; bit 0 is the ones digit.

Function
REQ-010 The FSM SHALL have states IDLE, CONV and COMMIT; ready SHALL be 1 only in IDLE.
REQ-011 IDLE with load=1 at edge N SHALL capture value_i, moving to CONV at N; any other IDLE cycle stays in IDLE.
REQ-012 A captured value above 9999 SHALL be replaced by 9999 before conversion, and ovf SHALL take 1 at COMMIT; otherwise ovf SHALL take 0 at COMMIT.
REQ-013 CONV SHALL run double-dabble (add 3 to any BCD nibble >=5, then shift left one bit) for exactly 14 iterations, one per cycle, at edges N+1..N+14.
REQ-014 COMMIT SHALL copy the four BCD nibbles into the display registers at edge N+15 and return to IDLE; ready SHALL be 1 from N+15.
REQ-015 load asserted while ready=0 SHALL be ignored, with no effect on the conversion in progress.
REQ-016 The display registers SHALL change only in COMMIT; scanning SHALL continue from them throughout a conversion without glitches.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the digit index SHALL advance 0,1,2,3,0.
REQ-018 digit_sel SHALL equal the inverse of (1 << index), and digit_num SHALL equal the display nibble for that index, both registered and changing on the same edge.
REQ-019 Index and scan counter SHALL be unaffected by load, conversion and ovf.

Reset
REQ-020 With rst_n=0 at an edge: state=IDLE, ready=1, ovf=0, display registers=0, scan counter=0, index=0, digit_sel=4'b1110, digit_num=0.
REQ-021 Reset during CONV or COMMIT SHALL abort the conversion without updating the display registers beyond their reset values; a load coincident with reset SHALL be discarded.

Configuration
REQ-022 The macro SEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-023 When the macro is defined, at COMMIT every zero nibble above the most significant non-zero nibble SHALL be stored as 4'hF; the ones digit SHALL never be blanked, so value 0 shows as a single "0".
REQ-024 When the macro is undefined, all four nibbles SHALL be stored as converted, including leading zeros.

Verification (SCAN_DIV=4)
REQ-025 Release reset, no load -> digit_sel cycles 1110,1101,1011,0111 with each code held 4 cycles; digit_num=0 throughout.
REQ-026 load=1, value_i=1234 at edge N -> ready=0 over N..N+14; at N+15 ready=1, ovf=0, and the digit_num values for index 0..3 are 4,3,2,1.
REQ-027 value_i=12000 -> after COMMIT ovf=1, digits 9,9,9,9; a following load of 5 -> ovf=0.
REQ-028 value_i=42: with the macro defined, indices 2,3 show 4'hF; without it, they show 0.
REQ-029 load pulsed at N+5 during a 1234 conversion with value_i=7777 -> result still 1234, ready at N+15.
REQ-030 rst_n=0 at N+7 of a conversion -> next cycle all REQ-020 values; display stays 0 and no COMMIT occurs.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Load/status and display-scan signals of the seven-segment scan driver.
// The driver owns the slave side; whatever feeds values owns the master side.
interface seg_scan_driver_if;
  logic        load;
  logic [13:0] value_i;
  logic        ready;
  logic        ovf;
  logic [3:0]  digit_num;
  logic [3:0]  digit_sel;

  modport master (
    output load,
    output value_i,
    input  ready,
    input  ovf,
    input  digit_num,
    input  digit_sel
  );

  modport slave (
    input  load,
    input  value_i,
    output ready,
    output ovf,
    output digit_num,
    output digit_sel
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (double-dabble, one bit per cycle) feeding a 4-digit multiplexed
// seven-segment scanner. Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus_io
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [13:0] MaxDisp = 14'd9999;
  localparam logic [3:0]  LastIter = 4'd13;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  // Conversion state
  state_e      state_q;
  logic        ready_q;
  logic        ovf_q;
  logic        ovf_pend_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  iter_q;
  logic [15:0] disp_q;

  // Scan state
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      sel_q;
  logic [3:0]      num_q;

  logic        in_over;
  logic [13:0] in_sat;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic [13:0] bin_shift;
  logic [15:0] disp_commit;

  always_comb begin
    in_over = (bus_io.value_i > MaxDisp);
    in_sat  = in_over ? MaxDisp : bus_io.value_i;
  end

  // One double-dabble step: adjust every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = (bcd_adj << 1) | {15'd0, bin_q[13]};
    bin_shift = bin_q << 1;
  end

  always_comb begin
    disp_commit = bcd_q;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Ones digit is never blanked so a zero value still shows a single "0".
    if (bcd_q[15:12] == 4'd0) begin
      disp_commit[15:12] = 4'hF;
      if (bcd_q[11:8] == 4'd0) begin
        disp_commit[11:8] = 4'hF;
        if (bcd_q[7:4] == 4'd0) begin
          disp_commit[7:4] = 4'hF;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ready_q    <= 1'b1;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      disp_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.load) begin
            bin_q      <= in_sat;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= in_over;
            ready_q    <= 1'b0;
            state_q    <= StConv;
          end
        end
        StConv: begin
          bcd_q  <= bcd_shift;
          bin_q  <= bin_shift;
          iter_q <= iter_q + 4'd1;
          if (iter_q == LastIter) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          disp_q  <= disp_commit;
          ovf_q   <= ovf_pend_q;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Scan timing is free-running and independent of the converter.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= 4'b1110;
      num_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sel_q <= ~(4'b0001 << idx_d);
      num_q <= disp_q[{idx_d, 2'b00} +: 4];
    end
  end

  assign bus_io.ready     = ready_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.digit_sel = sel_q;
  assign bus_io.digit_num = num_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4: expected digit/ovf results are queued
// at each accepted load and compared once the scanned display shows the committed value.
module tb_seg_scan_driver;

  localparam int unsigned ScanDiv = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_driver_if bus_if ();

  seg_scan_driver #(
    .SCAN_DIV(ScanDiv)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ovf;
    logic [15:0] digits;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(int v);
    exp_t e;
    int   s;
    s = (v > 9999) ? 9999 : v;
    e.ovf = (v > 9999);
    e.digits[3:0]   = 4'(s % 10);
    e.digits[7:4]   = 4'((s / 10) % 10);
    e.digits[11:8]  = 4'((s / 100) % 10);
    e.digits[15:12] = 4'((s / 1000) % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (s < 1000) e.digits[15:12] = 4'hF;
    if (s < 100)  e.digits[11:8]  = 4'hF;
    if (s < 10)   e.digits[7:4]   = 4'hF;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_digits(input string tag, output logic [15:0] got);
    logic [3:0] sel_exp;
    int n;
    got = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      sel_exp = ~(4'b0001 << i);
      n = 0;
      while (bus_if.digit_sel !== sel_exp && n < 40) begin
        tick();
        n++;
      end
      check($sformatf("%s_sel%0d_seen", tag, i), 32'(n < 40), 32'd1);
      got[4*i +: 4] = bus_if.digit_num;
    end
  endtask

  // Accept one value; optionally pulse a stray load inj_at samples after the accepting edge.
  task automatic do_load(input int v, input int inj_at, input int inj_val);
    exp_t        e;
    logic [15:0] got;
    int          busy;
    int          k;
    string       tag;
    tag = $sformatf("val%0d", v);
    bus_if.load    = 1'b1;
    bus_if.value_i = 14'(v);
    sb.push_back(model(v));
    tick();
    busy = 0;
    k = 0;
    while (bus_if.ready === 1'b0 && k < 40) begin
      busy++;
      if (k == inj_at) begin
        bus_if.load    = 1'b1;
        bus_if.value_i = 14'(inj_val);
      end else begin
        bus_if.load = 1'b0;
      end
      tick();
      k++;
    end
    bus_if.load = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy), 32'd15);
    check({tag, "_ready"}, 32'(bus_if.ready), 32'd1);
    e = sb.pop_front();
    check({tag, "_ovf"}, 32'(bus_if.ovf), 32'(e.ovf));
    read_digits(tag, got);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_digit%0d", tag, i), 32'(got[4*i +: 4]), 32'(e.digits[4*i +: 4]));
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [3:0]  sel_exp;
    int          not_ready;

    bus_if.load    = 1'b0;
    bus_if.value_i = '0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus_if.ready), 32'd1);
    check("rst_ovf", 32'(bus_if.ovf), 32'd0);
    check("rst_sel", 32'(bus_if.digit_sel), 32'hE);
    check("rst_num", 32'(bus_if.digit_num), 32'd0);

    // Free-running scan: each select code held ScanDiv cycles, blank display reads 0.
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sel_exp = ~(4'b0001 << ((k / ScanDiv) % 4));
      check($sformatf("scan_sel_k%0d", k), 32'(bus_if.digit_sel), 32'(sel_exp));
      check($sformatf("scan_num_k%0d", k), 32'(bus_if.digit_num), 32'd0);
      tick();
    end

    // Reset at N+7 of a conversion, with a coincident load that must be dropped.
    bus_if.load    = 1'b1;
    bus_if.value_i = 14'd1234;
    tick();
    bus_if.load = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst_n          = 1'b0;
    bus_if.load    = 1'b1;
    bus_if.value_i = 14'd5678;
    tick();
    check("abort_ready", 32'(bus_if.ready), 32'd1);
    check("abort_ovf", 32'(bus_if.ovf), 32'd0);
    check("abort_sel", 32'(bus_if.digit_sel), 32'hE);
    check("abort_num", 32'(bus_if.digit_num), 32'd0);
    rst_n       = 1'b1;
    bus_if.load = 1'b0;
    not_ready = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus_if.ready !== 1'b1) not_ready++;
      tick();
    end
    check("abort_no_conv", 32'(not_ready), 32'd0);
    read_digits("abort", got);
    check("abort_display", 32'(got), 32'd0);

    do_load(1234, -1, 0);
    do_load(12000, -1, 0);
    do_load(5, -1, 0);
    do_load(42, -1, 0);
    do_load(1234, 4, 7777);
    do_load(0, -1, 0);
    do_load(9999, -1, 0);
    do_load(10000, -1, 0);
    do_load(16383, -1, 0);
    do_load(907, -1, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
